// File: rtl/spi_reg_ctrl.sv
// SPI register-access controller: parses command bytes, sequences
// auto-incrementing register reads/writes and supplies MISO bytes.
module spi_reg_ctrl #(
  parameter int          NREGS      = 8,
  parameter logic [7:0]  ID_VAL     = 8'hC3,
  parameter logic [7:0]  STATUS_VAL = 8'h5A,
  parameter logic [7:0]  RESET_VAL  = 8'h00,
  localparam int         AW         = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic [7:0]        tx_byte,
  output logic              tx_load,
  output logic [8*NREGS-1:0] regs_o,
  output logic              wr_strobe,
  output logic [AW-1:0]     wr_addr,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, CMD, WRITE, READ, DRAIN
  } state_t;

  state_t  state, state_n;
  logic [AW-1:0] ptr, ptr_n;
  logic [7:0] tx_n;
  logic load_n;
  logic we;
  logic bad;
  logic [AW-1:0] addr;
  logic [AW-1:0] rd_addr;
  logic [7:0] rd_byte;
  logic [NREGS-1:1][7:0] data_q;

  // Register 0 is the constant ID, never stored.
  assign regs_o  = {data_q, ID_VAL};
  assign addr    = rx_byte[AW-1:0];
  assign bad     = {1'b0, rx_byte[6:0]} >= 8'(NREGS);
  assign rd_addr = (state == CMD) ? addr : ptr;
  assign rd_byte = regs_o[8*int'(rd_addr) +: 8];

  // Wrap at NREGS, not at the power-of-two pointer range.
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(NREGS-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    tx_n    = tx_byte;
    load_n  = 1'b0;
    we      = 1'b0;
    if (frame_end) begin
      state_n = IDLE;
    end else if (frame_start) begin
      state_n = CMD;
      tx_n    = STATUS_VAL;
      load_n  = 1'b1;
    end else if (rx_valid) begin
      case (state)
        CMD: begin
          load_n = 1'b1;
          if (bad) begin
            state_n = DRAIN;
            tx_n    = 8'hFF;
          end else if (rx_byte[7]) begin
            state_n = WRITE;
            ptr_n   = addr;
            tx_n    = rx_byte;
          end else begin
            state_n = READ;
            tx_n    = rd_byte;
            ptr_n   = inc(addr);
          end
        end
        WRITE: begin
          load_n = 1'b1;
          we     = (ptr != '0);
          tx_n   = rx_byte;
          ptr_n  = inc(ptr);
        end
        READ: begin
          load_n = 1'b1;
          tx_n   = rd_byte;
          ptr_n  = inc(ptr);
        end
        DRAIN: begin
          load_n = 1'b1;
          tx_n   = 8'hFF;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      tx_byte   <= 8'h00;
      tx_load   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      tx_byte   <= tx_n;
      tx_load   <= load_n;
      wr_strobe <= we;
      busy      <= (state_n != IDLE);
      if (we) wr_addr <= ptr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= {(NREGS-1){RESET_VAL}};
    end else begin
      for (int i = 1; i < NREGS; i++)
        if (we && ptr == AW'(i)) data_q[i] <= rx_byte;
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: expected tx bytes and register
// writes are queued by stimulus and checked by a negedge monitor.
module tb_spi_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_start = 1'b0;
  logic        frame_end = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic [7:0]  tx_byte;
  logic        tx_load;
  logic [63:0] regs_o;
  logic        wr_strobe;
  logic [2:0]  wr_addr;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [7:0]  txq[$];
  logic [10:0] wq[$];

  spi_reg_ctrl dut (
    .clk(clk), .rst(rst),
    .frame_start(frame_start), .frame_end(frame_end),
    .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_byte(tx_byte), .tx_load(tx_load),
    .regs_o(regs_o), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic fs, input logic fe,
                       input logic rv, input logic [7:0] b);
    frame_start = fs;
    frame_end   = fe;
    rx_valid    = rv;
    rx_byte     = b;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    rx_valid    = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    drive(1'b0, 1'b0, 1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic ex_tx(input logic [7:0] b);
    txq.push_back(b);
  endtask

  task automatic ex_wr(input logic [2:0] a, input logic [7:0] d);
    wq.push_back({a, d});
  endtask

  task automatic drained(input string name);
    idle(2);
    chk({name, "_txq_left"}, 64'(txq.size()), 64'd0);
    chk({name, "_wq_left"}, 64'(wq.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_load) begin
        checks++;
        if (txq.size() == 0) begin
          failures++;
          $display("FAIL tx_unexpected got=%h", tx_byte);
        end else begin
          logic [7:0] e;
          e = txq.pop_front();
          if (tx_byte !== e) begin
            failures++;
            $display("FAIL tx_byte got=%h exp=%h", tx_byte, e);
          end
        end
      end
      if (wr_strobe) begin
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL wr_unexpected addr=%0d", wr_addr);
        end else begin
          logic [10:0] e;
          logic [7:0]  d;
          e = wq.pop_front();
          d = regs_o[8*int'(wr_addr) +: 8];
          if (wr_addr !== e[10:8] || d !== e[7:0]) begin
            failures++;
            $display("FAIL wr got=%0d/%h exp=%0d/%h",
                     wr_addr, d, e[10:8], e[7:0]);
          end
        end
      end
    end
  end

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_regs", regs_o, 64'h0000_0000_0000_00C3);
    chk("rst_outs", {tx_byte, tx_load, wr_strobe, wr_addr, busy}, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // write burst
    ex_tx(8'h5A); ex_tx(8'h83); ex_tx(8'h11); ex_tx(8'h22);
    ex_wr(3, 8'h11); ex_wr(4, 8'h22);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    chk("busy_rise", busy, 1);
    send(8'h83); send(8'h11); send(8'h22);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    chk("busy_fall", busy, 0);
    drained("wburst");
    chk("reg3", regs_o[31:24], 8'h11);
    chk("reg4", regs_o[39:32], 8'h22);

    // preload reg7, then read with wrap
    ex_tx(8'h5A); ex_tx(8'h87); ex_tx(8'h77); ex_wr(7, 8'h77);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    send(8'h87); send(8'h77);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    ex_tx(8'h5A); ex_tx(8'h77); ex_tx(8'hC3); ex_tx(8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    send(8'h07); send(8'h00); send(8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    drained("rdwrap");

    // write wrapping through read-only reg0
    ex_tx(8'h5A); ex_tx(8'h87); ex_tx(8'hAA);
    ex_tx(8'hBB); ex_tx(8'hCC);
    ex_wr(7, 8'hAA); ex_wr(1, 8'hCC);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    send(8'h87); send(8'hAA); send(8'hBB); send(8'hCC);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    drained("wwrap");
    chk("wwrap_regs", regs_o, 64'hAA00_0022_1100_CCC3);

    // invalid address drains
    ex_tx(8'h5A); ex_tx(8'hFF); ex_tx(8'hFF); ex_tx(8'hFF);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    send(8'h08); send(8'h12); send(8'h34);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    drained("inval");
    chk("inval_regs", regs_o, 64'hAA00_0022_1100_CCC3);

    // frame_end collides with rx_valid, then clean restart
    ex_tx(8'h5A); ex_tx(8'h82);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    send(8'h82);
    chk("busy_mid", busy, 1);
    drive(1'b0, 1'b1, 1'b1, 8'h55);
    chk("busy_coll", busy, 0);
    ex_tx(8'h5A); ex_tx(8'h85); ex_tx(8'h66); ex_wr(5, 8'h66);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    send(8'h85); send(8'h66);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    drained("coll");
    chk("coll_reg2", regs_o[23:16], 8'h00);
    chk("coll_reg5", regs_o[47:40], 8'h66);

    // missed frame_end: frame_start restarts in CMD
    ex_tx(8'h5A); ex_tx(8'h82); ex_tx(8'h5A); ex_tx(8'h11);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    send(8'h82);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    send(8'h03);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    drained("restart");
    chk("restart_reg2", regs_o[23:16], 8'h00);

    // rx_valid in IDLE is ignored
    send(8'h44);
    drained("idle_rx");
    chk("idle_busy", busy, 0);

    // reset mid-frame
    ex_tx(8'h5A); ex_tx(8'h86); ex_tx(8'h99); ex_wr(6, 8'h99);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    send(8'h86); send(8'h99);
    idle(1);
    chk("pre_rst_reg6", regs_o[55:48], 8'h99);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_regs", regs_o, 64'h0000_0000_0000_00C3);
    chk("mid_rst_outs",
        {tx_byte, tx_load, wr_strobe, wr_addr, busy}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_rst_txq", 64'(txq.size()), 64'd0);
    idle(2);
    chk("post_rst_idle", {tx_load, wr_strobe, busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
